// File: rtl/gpr_file_sb_pkg.sv
// Shared definitions for the GPR file and its pending-write scoreboard.
package gpr_file_sb_pkg;

  localparam int GPR_NUM_LEN = 5;
  localparam int GPR_CNT     = 32;

  typedef logic [GPR_NUM_LEN-1:0] gpr_num_t;

endpackage

// File: rtl/gpr_file_sb_pend_cnt.sv
// Pending-write counter for one register: next = cnt + inc - dec, clamped to
// [0, 2^CNT_W-1]. Underflow is reported only when the update is not discarded
// by a flush.
module gpr_file_sb_pend_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [CNT_W+1:0] inc,
  input  logic [CNT_W+1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             underflow
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  logic [SW-1:0]    sum;
  logic [SW-1:0]    diff;
  logic [CNT_W-1:0] nxt;

  // Widened add/subtract with saturation at both ends.
  always_comb begin
    sum       = {2'b00, cnt} + inc;
    diff      = sum - dec;
    underflow = 1'b0;
    if (sum < dec) begin
      nxt       = '0;
      underflow = ~flush;
    end else if (diff > CNT_MAX) begin
      nxt = CNT_MAX[CNT_W-1:0];
    end else begin
      nxt = diff[CNT_W-1:0];
    end
  end

  // Counter register; flush drops the whole reservation set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

  assign nonzero = (cnt != '0);

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port GPR file with a per-register pending-write scoreboard.
// r0 reads as zero and ignores writes, issues and retires.
// Optional build macro GPR_BYPASS_EN: same-cycle write data is forwarded to
// the read ports, and busy drops when the forwarded write retires the last
// outstanding reservation.
module gpr_file_sb
  import gpr_file_sb_pkg::*;
#(
  parameter int NR    = 4,
  parameter int NW    = 2,
  parameter int NI    = 2,
  parameter int DW    = 32,
  parameter int CNT_W = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR*GPR_NUM_LEN-1:0] rd_num_i,
  output logic [NR*DW-1:0]          rd_data_o,
  output logic [NR-1:0]             busy_o,
  input  logic [NW-1:0]             wr_en_i,
  input  logic [NW*GPR_NUM_LEN-1:0] wr_num_i,
  input  logic [NW*DW-1:0]          wr_data_i,
  input  logic [NW-1:0]             wr_retire_i,
  input  logic [NI-1:0]             iss_en_i,
  input  logic [NI*GPR_NUM_LEN-1:0] iss_num_i,
  output logic [NI-1:0]             issue_ready_o,
  input  logic                      flush_i,
  output logic                      sb_err_o
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

  gpr_num_t         rd_num  [NR];
  gpr_num_t         wr_num  [NW];
  logic [DW-1:0]    wr_data [NW];
  gpr_num_t         iss_num [NI];

  logic [DW-1:0]    regs [GPR_CNT];
  logic [CNT_W-1:0] cnt  [GPR_CNT];
  logic [SW-1:0]    inc  [GPR_CNT];
  logic [SW-1:0]    dec  [GPR_CNT];
  logic [GPR_CNT-1:0] nonzero;
  logic [GPR_CNT-1:0] underflow;
  logic [NI-1:0]    iss_acc;

  // Unpack the flat port buses into per-port fields.
  always_comb begin
    for (int j = 0; j < NR; j++) rd_num[j] = rd_num_i[j*GPR_NUM_LEN +: GPR_NUM_LEN];
    for (int w = 0; w < NW; w++) begin
      wr_num[w]  = wr_num_i[w*GPR_NUM_LEN +: GPR_NUM_LEN];
      wr_data[w] = wr_data_i[w*DW +: DW];
    end
    for (int k = 0; k < NI; k++) iss_num[k] = iss_num_i[k*GPR_NUM_LEN +: GPR_NUM_LEN];
  end

  // Issue acceptance: each port sees the registered count plus the
  // reservations already accepted on lower-index ports for the same register.
  always_comb begin
    logic [NI-1:0] acc;
    logic [NI-1:0] ready;
    logic [SW-1:0] ahead;
    acc   = '0;
    ready = '0;
    ahead = '0;
    for (int k = 0; k < NI; k++) begin
      ahead = '0;
      for (int m = 0; m < k; m++) begin
        if (acc[m] && (iss_num[m] == iss_num[k])) ahead = ahead + SW'(1);
      end
      if (!iss_en_i[k] || (iss_num[k] == '0)) begin
        ready[k] = 1'b1;
      end else begin
        ready[k] = (({2'b00, cnt[iss_num[k]]} + ahead + SW'(1)) <= CNT_MAX);
      end
      acc[k] = rst && iss_en_i[k] && (iss_num[k] != '0) && ready[k];
    end
    iss_acc       = acc;
    issue_ready_o = rst ? ready : '0;
  end

  // Per-register increment/decrement counts for this cycle.
  always_comb begin
    for (int r = 0; r < GPR_CNT; r++) begin
      inc[r] = '0;
      dec[r] = '0;
    end
    for (int k = 0; k < NI; k++) begin
      if (iss_acc[k]) inc[iss_num[k]] = inc[iss_num[k]] + SW'(1);
    end
    for (int w = 0; w < NW; w++) begin
      if (wr_en_i[w] && wr_retire_i[w] && (wr_num[w] != '0))
        dec[wr_num[w]] = dec[wr_num[w]] + SW'(1);
    end
  end

  assign cnt[0]       = '0;
  assign nonzero[0]   = 1'b0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < GPR_CNT; r++) begin : g_cnt
    gpr_file_sb_pend_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .inc       (inc[r]),
      .dec       (dec[r]),
      .cnt       (cnt[r]),
      .nonzero   (nonzero[r]),
      .underflow (underflow[r])
    );
  end

  // Register array write; later ports overwrite earlier ones on a WAW clash.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < GPR_CNT; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en_i[w] && (wr_num[w] != '0)) regs[wr_num[w]] <= wr_data[w];
      end
    end
  end

  // Read ports and busy flags, optionally with same-cycle forwarding.
  always_comb begin
    logic [DW-1:0] data;
    logic          bsy;
`ifdef GPR_BYPASS_EN
    logic          hit;
    logic          hit_ret;
`endif
    rd_data_o = '0;
    busy_o    = '0;
    for (int j = 0; j < NR; j++) begin
      data = (rd_num[j] == '0) ? '0 : regs[rd_num[j]];
      bsy  = nonzero[rd_num[j]];
`ifdef GPR_BYPASS_EN
      hit     = 1'b0;
      hit_ret = 1'b0;
      for (int w = 0; w < NW; w++) begin
        if (wr_en_i[w] && (wr_num[w] == rd_num[j]) && (rd_num[j] != '0)) begin
          data    = wr_data[w];
          hit     = 1'b1;
          hit_ret = wr_retire_i[w];
        end
      end
      if (hit && hit_ret && (cnt[rd_num[j]] == CNT_W'(1))) bsy = 1'b0;
`endif
      if (!rst) begin
        data = '0;
        bsy  = 1'b0;
      end
      rd_data_o[j*DW +: DW] = data;
      busy_o[j]             = bsy;
    end
  end

  // Sticky scoreboard error on any retire without a matching reservation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_err_o <= 1'b0;
    end else if (|underflow) begin
      sb_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Bench for gpr_file_sb: directed vector table followed by randomized cycles
// checked against a behavioural scoreboard model.
module tb_gpr_file_sb;

  localparam int NR    = 4;
  localparam int NW    = 2;
  localparam int NI    = 2;
  localparam int DW    = 32;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*5-1:0]   rd_num;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     busy;
  logic [NW-1:0]     wr_en;
  logic [NW*5-1:0]   wr_num;
  logic [NW*DW-1:0]  wr_data;
  logic [NW-1:0]     wr_retire;
  logic [NI-1:0]     iss_en;
  logic [NI*5-1:0]   iss_num;
  logic [NI-1:0]     issue_ready;
  logic              flush;
  logic              sb_err;

  always #5 clk = ~clk;

  gpr_file_sb #(.NR(NR), .NW(NW), .NI(NI), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_num_i      (rd_num),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .wr_en_i       (wr_en),
    .wr_num_i      (wr_num),
    .wr_data_i     (wr_data),
    .wr_retire_i   (wr_retire),
    .iss_en_i      (iss_en),
    .iss_num_i     (iss_num),
    .issue_ready_o (issue_ready),
    .flush_i       (flush),
    .sb_err_o      (sb_err)
  );

  int passed = 0;
  int total  = 0;

  // Behavioural model state
  int          cnt_m  [32];
  logic [31:0] regs_m [32];
  bit          err_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] m_rd(input int j);
    logic [4:0]    n;
    logic [DW-1:0] v;
    n = rd_num[j*5 +: 5];
    if (!rst || n == 0) return '0;
    v = regs_m[n];
    if (BYP)
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && wr_num[w*5 +: 5] == n) v = wr_data[w*DW +: DW];
    return v;
  endfunction

  function automatic logic m_busy(input int j);
    logic [4:0] n;
    logic       b, hit, ret;
    n = rd_num[j*5 +: 5];
    if (!rst || n == 0) return 1'b0;
    b   = (cnt_m[n] != 0);
    hit = 1'b0;
    ret = 1'b0;
    if (BYP) begin
      for (int w = 0; w < NW; w++)
        if (wr_en[w] && wr_num[w*5 +: 5] == n) begin
          hit = 1'b1;
          ret = wr_retire[w];
        end
      if (hit && ret && cnt_m[n] == 1) b = 1'b0;
    end
    return b;
  endfunction

  // Hand out reservations in port order against a scratch copy of the counts.
  function automatic logic [NI-1:0] m_ready();
    int            tmp [32];
    logic [NI-1:0] r;
    logic [4:0]    n;
    tmp = cnt_m;
    r   = '0;
    for (int k = 0; k < NI; k++) begin
      n = iss_num[k*5 +: 5];
      if (!rst) r[k] = 1'b0;
      else if (!iss_en[k] || n == 0) r[k] = 1'b1;
      else if (tmp[n] < MAXC) begin
        r[k] = 1'b1;
        tmp[n]++;
      end else r[k] = 1'b0;
    end
    return r;
  endfunction

  task automatic m_update();
    logic [NI-1:0] rdy;
    int            d;
    rdy = m_ready();
    if (!rst) begin
      for (int r = 0; r < 32; r++) begin
        cnt_m[r]  = 0;
        regs_m[r] = '0;
      end
      err_m = 1'b0;
      return;
    end
    for (int w = 0; w < NW; w++)
      if (wr_en[w] && wr_num[w*5 +: 5] != 0) regs_m[wr_num[w*5 +: 5]] = wr_data[w*DW +: DW];
    if (flush) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        d = cnt_m[r];
        for (int k = 0; k < NI; k++)
          if (rdy[k] && iss_en[k] && iss_num[k*5 +: 5] == r) d++;
        for (int w = 0; w < NW; w++)
          if (wr_en[w] && wr_retire[w] && wr_num[w*5 +: 5] == r) d--;
        if (d < 0) begin
          err_m = 1'b1;
          d = 0;
        end
        if (d > MAXC) d = MAXC;
        cnt_m[r] = d;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic        rst;
    logic [4:0]  rd;
    logic [1:0]  we;
    logic [4:0]  wn0;
    logic [31:0] wd0;
    logic [4:0]  wn1;
    logic [31:0] wd1;
    logic [1:0]  wret;
    logic [1:0]  ie;
    logic [4:0]  in0;
    logic [4:0]  in1;
    logic        fl;
    logic [31:0] e_rd;
    logic        e_busy;
    logic [1:0]  e_rdy;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [4:0] rd, logic [1:0] we, logic [4:0] wn0,
                              logic [31:0] wd0, logic [4:0] wn1, logic [31:0] wd1,
                              logic [1:0] wret, logic [1:0] ie, logic [4:0] in0,
                              logic [4:0] in1, logic fl, logic [31:0] e_rd, logic e_busy,
                              logic [1:0] e_rdy, logic e_err);
    vec_t v;
    v.rst = r;   v.rd = rd;   v.we = we;   v.wn0 = wn0; v.wd0 = wd0;
    v.wn1 = wn1; v.wd1 = wd1; v.wret = wret; v.ie = ie; v.in0 = in0;
    v.in1 = in1; v.fl = fl;   v.e_rd = e_rd; v.e_busy = e_busy;
    v.e_rdy = e_rdy; v.e_err = e_err;
    return v;
  endfunction

  initial begin
    vec_t v;
    rst = 1'b0; rd_num = '0; wr_en = '0; wr_num = '0; wr_data = '0; wr_retire = '0;
    iss_en = '0; iss_num = '0; flush = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_m[r] = 0;
      regs_m[r] = '0;
    end
    err_m = 1'b0;

    //            rst rd  we    wn0 wd0            wn1 wd1    wret  ie    in0 in1 fl  e_rd                       bsy       rdy   err
    tbl.push_back(mk(0, 5, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h0,                      0,        2'b00, 0));
    tbl.push_back(mk(0, 5, 2'b01, 5, 32'h55,        0, 0,      2'b00, 2'b01, 5, 0, 0, 32'h0,                      0,        2'b00, 0));
    tbl.push_back(mk(1, 5, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 7, 2'b11, 7, 32'h11,        7, 32'h22, 2'b00, 2'b00, 0, 0, 0, BYP ? 32'h22 : 32'h0,       0,        2'b11, 0));
    tbl.push_back(mk(1, 7, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h22,                     0,        2'b11, 0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, 0,      2'b00, 2'b01, 0, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 3, 2'b00, 0, 0,             0, 0,      2'b00, 2'b01, 3, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 3, 2'b00, 0, 0,             0, 0,      2'b00, 2'b01, 3, 0, 0, 32'h0,                      1,        2'b11, 0));
    tbl.push_back(mk(1, 3, 2'b00, 0, 0,             0, 0,      2'b00, 2'b11, 3, 3, 0, 32'h0,                      1,        2'b01, 0));
    tbl.push_back(mk(1, 3, 2'b00, 0, 0,             0, 0,      2'b00, 2'b01, 3, 0, 0, 32'h0,                      1,        2'b10, 0));
    tbl.push_back(mk(1, 3, 2'b11, 3, 0,             3, 0,      2'b11, 2'b00, 0, 0, 0, 32'h0,                      1,        2'b11, 0));
    tbl.push_back(mk(1, 3, 2'b01, 3, 0,             0, 0,      2'b01, 2'b00, 0, 0, 0, 32'h0,                      BYP ? 1'b0 : 1'b1, 2'b11, 0));
    tbl.push_back(mk(1, 3, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 9, 2'b00, 0, 0,             0, 0,      2'b00, 2'b01, 9, 0, 0, 32'h0,                      0,        2'b11, 0));
    tbl.push_back(mk(1, 9, 2'b01, 9, 32'h99,        0, 0,      2'b01, 2'b01, 9, 0, 0, BYP ? 32'h99 : 32'h0,       BYP ? 1'b0 : 1'b1, 2'b11, 0));
    tbl.push_back(mk(1, 9, 2'b01, 9, 32'h9A,        0, 0,      2'b01, 2'b00, 0, 0, 0, BYP ? 32'h9A : 32'h99,      BYP ? 1'b0 : 1'b1, 2'b11, 0));
    tbl.push_back(mk(1, 9, 2'b01, 9, 32'h9B,        0, 0,      2'b01, 2'b00, 0, 0, 0, BYP ? 32'h9B : 32'h9A,      0,        2'b11, 0));
    tbl.push_back(mk(1, 9, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h9B,                     0,        2'b11, 1));
    tbl.push_back(mk(1, 9, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h9B,                     0,        2'b11, 1));
    tbl.push_back(mk(1, 4, 2'b00, 0, 0,             0, 0,      2'b00, 2'b11, 4, 4, 0, 32'h0,                      0,        2'b11, 1));
    tbl.push_back(mk(1, 4, 2'b00, 0, 0,             0, 0,      2'b00, 2'b01, 8, 0, 0, 32'h0,                      1,        2'b11, 1));
    tbl.push_back(mk(1, 8, 2'b01, 8, 32'hAB,        0, 0,      2'b00, 2'b01, 4, 0, 1, BYP ? 32'hAB : 32'h0,       1,        2'b11, 1));
    tbl.push_back(mk(1, 8, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'hAB,                     0,        2'b11, 1));
    tbl.push_back(mk(1, 4, 2'b00, 0, 0,             0, 0,      2'b00, 2'b00, 0, 0, 0, 32'h0,                      0,        2'b11, 1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      rst       = v.rst;
      rd_num    = {NR{v.rd}};
      wr_en     = v.we;
      wr_num    = {v.wn1, v.wn0};
      wr_data   = {v.wd1, v.wd0};
      wr_retire = v.wret;
      iss_en    = v.ie;
      iss_num   = {v.in1, v.in0};
      flush     = v.fl;
      #1;
      for (int j = 0; j < NR; j++)
        chk($sformatf("vec%0d rd_data[%0d]", i, j), 64'(rd_data[j*DW +: DW]), 64'(v.e_rd));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'({NR{v.e_busy}}));
      chk($sformatf("vec%0d issue_ready", i), 64'(issue_ready), 64'(v.e_rdy));
      chk($sformatf("vec%0d sb_err", i), 64'(sb_err), 64'(v.e_err));
      tick();
    end

    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 59) != 0);
      flush = ($urandom_range(0, 15) == 0);
      for (int j = 0; j < NR; j++) rd_num[j*5 +: 5] = 5'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) begin
        wr_num[w*5 +: 5]   = 5'($urandom_range(0, 7));
        wr_data[w*DW +: DW] = $urandom;
      end
      for (int k = 0; k < NI; k++) iss_num[k*5 +: 5] = 5'($urandom_range(0, 7));
      wr_en     = NW'($urandom);
      wr_retire = NW'($urandom) & NW'($urandom);
      iss_en    = NI'($urandom);
      #1;
      for (int j = 0; j < NR; j++) begin
        chk($sformatf("rnd%0d rd_data[%0d]", c, j), 64'(rd_data[j*DW +: DW]), 64'(m_rd(j)));
        chk($sformatf("rnd%0d busy[%0d]", c, j), 64'(busy[j]), 64'(m_busy(j)));
      end
      chk($sformatf("rnd%0d issue_ready", c), 64'(issue_ready), 64'(m_ready()));
      chk($sformatf("rnd%0d sb_err", c), 64'(sb_err), 64'(err_m));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
